// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and constants for the two-port RAM arbiter.
//   AW_DEF/DW_DEF : default address/data widths (1024x8 RAM)
//   P0/P1         : port indices used for owner/grant values
//   state_t       : controller FSM states
package ram_ctrl_pkg;
    localparam int AW_DEF = 10;
    localparam int DW_DEF = 8;
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;
    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, DONE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-input round-robin arbiter.
//   req[1:0]   : request lines from port 1 / port 0
//   last_grant : port granted most recently (register kept by the parent)
//   en         : arbitration allowed this cycle
//   grant      : index of the winning port
//   valid      : a grant is being issued
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic       grant,
    output logic       valid
);
    always_comb begin
        valid = en && |req;
        grant = &req ? ~last_grant : (req[1] ? P1 : P0);
    end
endmodule

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: round-robin front end serialising two masters onto a single-port sync RAM.
//   clk, rst_n                 : clock, synchronous active-low reset
//   req*/we*/addr*/wdata*      : master request, held until ack
//   ack*                       : one-cycle completion pulse
//   rdata*                     : read result, held until that port's next read ack
//   mem_cs/mem_rw/mem_addr     : registered RAM controls
//   mem_data                   : shared RAM data bus, driven here only during a write
module ram_arbiter_2p
    import ram_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_cs,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data
);
    state_t state, nxt;
    logic owner, last_grant, grant, valid;
    logic [DW-1:0] wdata_l;

    rr_arb2 u_arb (
        .req       ({req1, req0}),
        .last_grant(last_grant),
        .en        (state == IDLE),
        .grant     (grant),
        .valid     (valid)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = valid ? ((grant ? we1 : we0) ? WR : RD1) : IDLE;
            WR:      nxt = DONE;
            RD1:     nxt = RD2;
            RD2:     nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    // Controls are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= P0;
            last_grant <= P1;
            wdata_l    <= '0;
            mem_cs     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state  <= nxt;
            mem_cs <= nxt inside {WR, RD1, RD2};
            mem_rw <= nxt == WR;
            ack0   <= nxt == DONE && owner == P0;
            ack1   <= nxt == DONE && owner == P1;
            if (state == IDLE && valid) begin
                owner      <= grant;
                last_grant <= grant;
                mem_addr   <= grant ? addr1 : addr0;
                wdata_l    <= grant ? wdata1 : wdata0;
            end
            if (state == RD2 && owner == P0)
                rdata0 <= mem_data;
            if (state == RD2 && owner == P1)
                rdata1 <= mem_data;
        end
    end

    assign mem_data = (mem_cs && mem_rw) ? wdata_l : {DW{1'bz}};
endmodule

// File: doc/ram_arbiter_2p.md
# ram_arbiter_2p

Two-requester round-robin controller for the single-port 1024x8 synchronous RAM (cs/rw/addr and a shared bidirectional data bus). It sits between two independent masters and the RAM, serialises their read/write requests, sequences the RAM's two-cycle read protocol, and owns the write side of the tri-state data bus. Each master sees a simple req/ack handshake with registered read data.

## Interface
- AW, 10, address width (RAM depth 2**AW)
- DW, 8, data width
- clk  in  1  system clock, all activity on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0 / req1  in  1  request from master 0 / 1, held until ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  AW  request address; stable while req high
- wdata0 / wdata1  in  DW  write data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read result, valid from ack, held until that port's next read ack
- mem_cs  out  1  RAM chip select
- mem_rw  out  1  RAM direction, 1 = write, 0 = read
- mem_addr  out  AW  RAM address
- mem_data  inout  DW  RAM data bus

## Operation
- FSM states: IDLE, WR, RD1, RD2, DONE. All mem_* controls and ack registered.
- IDLE: mem_cs=0. If any req high, arbitrate, latch owner, we, addr, wdata; go WR (we=1) or RD1 (we=0). Else stay.
- WR: mem_cs=1, mem_rw=1, mem_addr=latched addr, bus driven with latched wdata; RAM writes at end of cycle -> DONE.
- RD1: mem_cs=1, mem_rw=0, addr; RAM loads its output register at end of cycle -> RD2.
- RD2: same controls; RAM drives bus; controller samples mem_data into rdata[owner] at end of cycle -> DONE.
- DONE: mem_cs=0, ack[owner]=1 for exactly this cycle -> IDLE.
- Arbitration only in IDLE; masters drop or change req at the edge ending DONE, so no request is double-served.
- Round-robin: single req wins; both high -> port not granted last; last_grant resets to 1 (port 0 wins first tie).
- Bus: mem_data driven only when mem_cs && mem_rw; otherwise high-Z. Never driven in RD1/RD2/IDLE/DONE.
- Requester changing we/addr/wdata mid-transaction has no effect (latched at grant).

## Timing
- Reset values: state IDLE, mem_cs=0, mem_rw=0, mem_addr=0, ack0=ack1=0, rdata0=rdata1=0, last_grant=1, mem_data high-Z.
- Write: req sampled in IDLE cycle t; WR at t+1; ack at t+2. Occupancy 3 cycles.
- Read: req sampled at t; RD1 t+1; RD2 t+2; ack and rdata valid t+3. Occupancy 4 cycles.
- Both masters streaming: alternate grants strictly; second master waits at most one transaction.
- Reset mid-operation: next cycle state IDLE and all outputs at reset values, no ack issued. Reset asserted during WR still lets the RAM write at that edge (RAM has no reset); reads in flight discarded, rdata cleared.
- Address 0 and 1023 handled identically; no wrap logic in controller.

## Structure
- Shared package ram_ctrl_pkg: state enum (IDLE, WR, RD1, RD2, DONE), AW/DW defaults, port index constants P0=0, P1=1.
- Sub-module rr_arb2: two-input round-robin arbiter, inputs req[1:0], last_grant, en; outputs grant index and valid; combinational, last_grant register stays in parent.
- Top instantiates rr_arb2, FSM, latch registers, tri-state assign; bench instantiates top with the 1024x8 RAM model.

## Test plan
- Reset: hold rst_n=0 two cycles with random req -> all outputs at reset values, mem_data Z, no ack.
- Master 0 write 0xA5 @0x3FF, then read @0x3FF -> ack0 at t+2 for write; read ack0 at t+3 with rdata0=0xA5; rdata1 unchanged.
- Simultaneous req0 write 0x11 @0x000 and req1 read @0x000 from reset -> port 0 served first, port 1 then acks with rdata1=0x11.
- Both masters request continuously 6 transactions each -> grants strictly alternate 0,1,0,1...; no bus contention (mem_data never X).
- Reset asserted during RD1 of a read -> no ack, rdata cleared, next request after reset completes normally.
- Master changes addr0 during WR -> write lands at address latched at grant, verified by later read.
